// File: rtl/spi_master_ctrl_if.sv
// Host command/reply handshake plus the SS_n/MOSI/MISO bus of spi_master_ctrl.
// master: the controller's view; slave: the host/peripheral side that drives commands and MISO.
interface spi_master_ctrl_if #(
  parameter int CMD_W  = 10,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, resp_valid, resp_data, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, resp_valid, resp_data, busy, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-clock SPI initiator: one SS_n frame per command word, 8-bit MISO reply for read-data commands.
// Optional SPI_ABORT_EN adds abort/aborted ports that cancel a frame while SS_n is low.
module spi_master_ctrl #(
  parameter int CMD_W   = 10,
  parameter int DATA_W  = 8,
  parameter int RD_TURN = 2,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SPI_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  spi_master_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(CMD_W + RD_TURN + DATA_W + 2);

  // Reload values: a state lasting N cycles loads N-1 and leaves when the count hits zero.
  localparam logic [CNT_W-1:0] LD_OUT  = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] LD_TURN = CNT_W'(RD_TURN - 1);
  localparam logic [CNT_W-1:0] LD_IN   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD_BIT,
    SHIFT_OUT,
    TURN,
    SHIFT_IN,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic              is_rd_q, is_rd_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef SPI_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      is_rd_q   <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      rdata_q   <= '0;
`ifdef SPI_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      is_rd_q   <= is_rd_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
      rdata_q   <= rdata_d;
`ifdef SPI_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Every output is a register, so this block computes the values for the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    is_rd_d   = is_rd_q;
    ss_n_d    = 1'b1;
    mosi_d    = 1'b0;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    rv_d      = 1'b0;
    rdata_d   = rdata_q;
`ifdef SPI_ABORT_EN
    aborted_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.cmd_valid && ready_q) begin
          state_d = CMD_BIT;
          cnt_d   = '0;
          cmd_d   = bus.cmd_data;
          is_rd_d = (bus.cmd_data[CMD_W-1 -: 2] == 2'b11);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          ss_n_d  = 1'b0;
          mosi_d  = bus.cmd_data[CMD_W-1];
        end
      end

      CMD_BIT: begin
        state_d = SHIFT_OUT;
        cnt_d   = LD_OUT;
        ss_n_d  = 1'b0;
        mosi_d  = cmd_q[CMD_W-1];
        cmd_d   = {cmd_q[CMD_W-2:0], 1'b0};
      end

      // cmd_q is pre-shifted, so its MSB is always the next bit; count 1 -> 0 is the capture pad.
      SHIFT_OUT: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_W'(1);
          ss_n_d = 1'b0;
          mosi_d = (cnt_q != CNT_W'(1)) & cmd_q[CMD_W-1];
          cmd_d  = {cmd_q[CMD_W-2:0], 1'b0};
        end else if (is_rd_q) begin
          state_d = TURN;
          cnt_d   = LD_TURN;
          ss_n_d  = 1'b0;
        end else begin
          state_d = GAP;
          cnt_d   = LD_GAP;
        end
      end

      TURN: begin
        ss_n_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = SHIFT_IN;
          cnt_d   = LD_IN;
        end
      end

      SHIFT_IN: begin
        shift_d = {shift_q[DATA_W-3:0], bus.MISO};
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_W'(1);
          ss_n_d = 1'b0;
        end else begin
          state_d = GAP;
          cnt_d   = LD_GAP;
          rv_d    = 1'b1;
          rdata_d = {shift_q, bus.MISO};
        end
      end

      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

`ifdef SPI_ABORT_EN
    if (abort && (state_q inside {CMD_BIT, SHIFT_OUT, TURN, SHIFT_IN})) begin
      state_d   = GAP;
      cnt_d     = LD_GAP;
      ss_n_d    = 1'b1;
      mosi_d    = 1'b0;
      rv_d      = 1'b0;
      rdata_d   = rdata_q;
      aborted_d = 1'b1;
    end
`endif
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_data  = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.SS_n       = ss_n_q;
  assign bus.MOSI       = mosi_q;
`ifdef SPI_ABORT_EN
  assign aborted        = aborted_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized scoreboard bench for spi_master_ctrl: expected frames are queued on accept and
// checked by a bus monitor; a slave model drives MISO replies for read-data commands.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
  localparam int CMD_W    = 10;
  localparam int DATA_W   = 8;
  localparam int RD_TURN  = 2;
  localparam int GAP_CYC  = 2;
  localparam int RD_START = 1 + CMD_W + 1 + RD_TURN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

`ifdef SPI_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  spi_master_ctrl #(
    .CMD_W  (CMD_W),
    .DATA_W (DATA_W),
    .RD_TURN(RD_TURN),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef SPI_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .bus    (bus)
  );

  typedef struct {
    logic [31:0]       mosi;
    int                len;
    bit                is_rd;
    logic [DATA_W-1:0] reply;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] miso_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame as seen on the wire: select bit, the whole word MSB first, a zero pad,
  // then zeros on MOSI for turnaround and reply when the opcode is read-data.
  function automatic exp_t model(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] rep);
    bit   q[$];
    exp_t e;
    q.push_back(c[CMD_W-1]);
    for (int i = CMD_W - 1; i >= 0; i--) q.push_back(c[i]);
    q.push_back(1'b0);
    e.is_rd = (c[CMD_W-1 -: 2] == 2'b11);
    if (e.is_rd) for (int i = 0; i < RD_TURN + DATA_W; i++) q.push_back(1'b0);
    e.mosi = '0;
    foreach (q[i]) e.mosi = {e.mosi[30:0], q[i]};
    e.len   = q.size();
    e.reply = rep;
    return e;
  endfunction

  task automatic send(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] rep, input int idle_after);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    while (!bus.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_in_time", 32'(t < 200), 32'd1);
    if (t < 200) begin
      exp_q.push_back(model(c, rep));
      if (c[CMD_W-1 -: 2] == 2'b11) miso_q.push_back(rep);
      @(posedge clk);
      #1;
    end
    if (idle_after > 0 || t >= 200) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = CMD_W'($urandom);
      repeat (idle_after) @(negedge clk);
    end
  endtask

  // Slave model: reply bits go out MSB first in the cycles after turnaround; elsewhere MISO is noise.
  int                low_idx = 0;
  logic [DATA_W-1:0] cur_reply = '0;
  initial begin
    bus.MISO = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.SS_n) begin
        if (low_idx == RD_START && miso_q.size() > 0) cur_reply = miso_q.pop_front();
        if (low_idx >= RD_START && low_idx < RD_START + DATA_W)
          bus.MISO = cur_reply[DATA_W-1-(low_idx-RD_START)];
        else
          bus.MISO = 1'($urandom);
        low_idx++;
      end else begin
        low_idx  = 0;
        bus.MISO = 1'($urandom);
      end
    end
  end

  bit                mon_en = 0;
  bit                in_frame = 0;
  bit                seen = 0;
  int                high_run = 0;
  int                flen = 0;
  logic [31:0]       mv = '0;
  logic [DATA_W-1:0] last_reply = '0;
  exp_t              e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.SS_n) begin
        if (!in_frame) begin
          in_frame = 1;
          if (seen) chk("gap_min_high", 32'(high_run >= GAP_CYC + 1), 32'd1);
          mv   = '0;
          flen = 0;
        end
        mv = {mv[30:0], bus.MOSI};
        flen++;
        chk("busy_in_frame", bus.busy, 1);
        chk("ready_in_frame", bus.cmd_ready, 0);
        chk("no_resp_in_frame", bus.resp_valid, 0);
      end else if (in_frame) begin
        in_frame = 0;
        seen     = 1;
        high_run = 1;
        chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_len", flen, e.len);
          chk("mosi_bits", mv, e.mosi);
          chk("resp_valid_end", bus.resp_valid, e.is_rd);
          if (e.is_rd) last_reply = e.reply;
          chk("resp_data", bus.resp_data, last_reply);
        end
      end else begin
        high_run++;
        chk("no_resp_idle", bus.resp_valid, 0);
        chk("busy_vs_ready", bus.busy, !bus.cmd_ready);
        chk("mosi_idle", bus.MOSI, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [CMD_W-1:0] c;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", bus.SS_n, 1);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", bus.cmd_ready, 1);

    // Reset while bit 5 of the command is on MOSI.
    c = 10'b01_0111_0000;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    t = 0;
    while (bus.SS_n && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("frame_start_in_time", 32'(t < 50), 32'd1);
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mosi_bit5_before_rst", bus.MOSI, c[CMD_W-1-5]);
    rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", bus.SS_n, 1);
    chk("midrst_mosi", bus.MOSI, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", bus.cmd_ready, 1);
    chk("midrst_ss_n_after", bus.SS_n, 1);
    mon_en = 1;

    send(10'b00_1010_0101, 8'h00, 0);
    send(10'b11_0000_0011, 8'hC3, 0);
    send(10'b01_0001_0000, 8'h00, 0);
    send(10'b10_0101_1010, 8'h00, 4);
    send(10'b01_0001_0000, 8'h00, 0);
    send(10'b11_0000_0000, 8'h5A, 7);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int idle;
      op   = 2'($urandom_range(0, 3));
      c    = {op, 8'($urandom)};
      idle = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
      send(c, DATA_W'($urandom), idle);
    end

    bus.cmd_valid = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_miso_q", miso_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
